// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS core pipeline control logic.
//   FWD_RF / FWD_WB / FWD_MEM : encodings of the EX-stage ALU operand source select
//   hz_state_t                : divide-tracking states used by the hazard controller
package mips_pkg;

    // ALU operand source selects driven into the EX-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // RUN: no divide outstanding, BUSY: divide result not yet in HI/LO
    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel
// Combinational forwarding comparator for one EX-stage ALU operand.
//   i_srcReg    : source register read by the EX instruction
//   i_writeRegM : destination register of the MEM-stage instruction
//   i_regWriteM : MEM-stage instruction writes the register file
//   i_writeRegW : destination register of the WB-stage instruction
//   i_regWriteW : WB-stage instruction writes the register file
//   o_fwdSel    : operand source (FWD_RF, FWD_WB or FWD_MEM)
module fwd_sel
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_srcReg,
    input  logic [REG_W-1:0] i_writeRegM,
    input  logic             i_regWriteM,
    input  logic [REG_W-1:0] i_writeRegW,
    input  logic             i_regWriteW,
    output logic [1:0]       o_fwdSel
);

    // MEM holds the younger result, so it is checked before WB. Register 0
    // is hard-wired to zero and must never be forwarded.
    always_comb begin
        o_fwdSel = FWD_RF;
        if (i_regWriteM && (i_writeRegM != '0) && (i_writeRegM == i_srcReg)) begin
            o_fwdSel = FWD_MEM;
        end else if (i_regWriteW && (i_writeRegW != '0) && (i_writeRegW == i_srcReg)) begin
            o_fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline hazard controller for the five-stage MIPS core.
//   clk, rst                  : clock and synchronous active-high reset
//   Rs_D, Rt_D                : source registers of the ID instruction
//   Rs_E, Rt_E                : source registers of the EX instruction
//   Mem_Read_E                : EX instruction is a load
//   Write_Reg_M/W, Reg_Write_M/W : MEM/WB destination register and write enable
//   branch_taken_E            : branch resolved taken in EX
//   div_D, mfhilo_D           : ID instruction is a divide / an mfhi-mflo
//   div_start_E               : divide enters EX this cycle
//   stall_F, stall_D          : hold PC / hold IF-ID
//   flush_D                   : clear IF-ID
//   clr_E                     : load a bubble into ID-EX
//   fwd_A_E, fwd_B_E          : ALU operand source selects
//   div_busy, div_done        : divide in flight / HI-LO valid pulse
module hazard_unit
    import mips_pkg::*;
#(
    parameter int DIV_LATENCY = 8,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs_D,
    input  logic [REG_W-1:0] Rt_D,
    input  logic [REG_W-1:0] Rs_E,
    input  logic [REG_W-1:0] Rt_E,
    input  logic             Mem_Read_E,
    input  logic [REG_W-1:0] Write_Reg_M,
    input  logic [REG_W-1:0] Write_Reg_W,
    input  logic             Reg_Write_M,
    input  logic             Reg_Write_W,
    input  logic             branch_taken_E,
    input  logic             div_D,
    input  logic             mfhilo_D,
    input  logic             div_start_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             clr_E,
    output logic [1:0]       fwd_A_E,
    output logic [1:0]       fwd_B_E,
    output logic             div_busy,
    output logic             div_done
);

    localparam int              CNT_W    = $clog2(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    hz_state_t        r_state;
    hz_state_t        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_divDone;
    logic             w_divDoneNext;

    logic             w_divBusy;
    logic             w_loadUse;
    logic             w_divHold;
    logic             w_stall;
    logic [1:0]       w_fwdA;
    logic [1:0]       w_fwdB;

    // Divide tracker state. Reset abandons any divide in flight, so no
    // completion pulse can follow a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_divDone <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_divDone <= w_divDoneNext;
        end
    end

    // The counter holds the number of BUSY cycles still to come after the
    // current one, so BUSY lasts exactly DIV_LATENCY cycles. A new issue while
    // BUSY restarts the count and suppresses the pending completion; the
    // count sits at zero on exit so it never wraps.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_divDoneNext = 1'b0;
        case (r_state)
            RUN: begin
                if (div_start_E) begin
                    w_stateNext = BUSY;
                    w_cntNext   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (div_start_E) begin
                    w_cntNext = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_stateNext   = RUN;
                    w_divDoneNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = RUN;
                w_cntNext   = '0;
            end
        endcase
    end

    // A load followed by a dependent instruction, or any HI/LO reader or
    // second divide while the divider is busy, gets a single combined
    // bubble. Register 0 never creates a load-use dependency.
    always_comb begin
        w_divBusy = (r_state == BUSY);
        w_loadUse = Mem_Read_E && (Rt_E != '0) && ((Rt_E == Rs_D) || (Rt_E == Rt_D));
        w_divHold = w_divBusy && (mfhilo_D || div_D);
        w_stall   = w_loadUse || w_divHold;
    end

    fwd_sel #(.REG_W(REG_W)) u_fwdA (
        .i_srcReg    (Rs_E),
        .i_writeRegM (Write_Reg_M),
        .i_regWriteM (Reg_Write_M),
        .i_writeRegW (Write_Reg_W),
        .i_regWriteW (Reg_Write_W),
        .o_fwdSel    (w_fwdA)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwdB (
        .i_srcReg    (Rt_E),
        .i_writeRegM (Write_Reg_M),
        .i_regWriteM (Reg_Write_M),
        .i_writeRegW (Write_Reg_W),
        .i_regWriteW (Reg_Write_W),
        .o_fwdSel    (w_fwdB)
    );

    // A taken branch discards the ID instruction anyway, so it wins over a
    // stall: the front end keeps moving and the wrong-path work is flushed.
    // Every control output is forced quiet while reset is held.
    always_comb begin
        stall_F  = !rst && w_stall && !branch_taken_E;
        stall_D  = !rst && w_stall && !branch_taken_E;
        flush_D  = !rst && branch_taken_E;
        clr_E    = !rst && (w_stall || branch_taken_E);
        fwd_A_E  = rst ? FWD_RF : w_fwdA;
        fwd_B_E  = rst ? FWD_RF : w_fwdB;
        div_busy = !rst && w_divBusy;
        div_done = !rst && r_divDone;
    end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int L  = 8;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] Rs_D, Rt_D, Rs_E, Rt_E, Write_Reg_M, Write_Reg_W;
    logic          Mem_Read_E, Reg_Write_M, Reg_Write_W, branch_taken_E;
    logic          div_D, mfhilo_D, div_start_E;
    logic          stall_F, stall_D, flush_D, clr_E, div_busy, div_done;
    logic [1:0]    fwd_A_E, fwd_B_E;
    logic [9:0]    dutOut;

    int errors = 0;
    int checks = 0;

    // Divide schedule kept as absolute cycle numbers
    int cyc    = 0;
    int busyLo = -1;
    int busyHi = -2;
    int doneAt = -1;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_LATENCY(L), .REG_W(RW)) dut (
        .clk            (clk),
        .rst            (rst),
        .Rs_D           (Rs_D),
        .Rt_D           (Rt_D),
        .Rs_E           (Rs_E),
        .Rt_E           (Rt_E),
        .Mem_Read_E     (Mem_Read_E),
        .Write_Reg_M    (Write_Reg_M),
        .Write_Reg_W    (Write_Reg_W),
        .Reg_Write_M    (Reg_Write_M),
        .Reg_Write_W    (Reg_Write_W),
        .branch_taken_E (branch_taken_E),
        .div_D          (div_D),
        .mfhilo_D       (mfhilo_D),
        .div_start_E    (div_start_E),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .clr_E          (clr_E),
        .fwd_A_E        (fwd_A_E),
        .fwd_B_E        (fwd_B_E),
        .div_busy       (div_busy),
        .div_done       (div_done)
    );

    assign dutOut = {stall_F, stall_D, flush_D, clr_E, fwd_A_E, fwd_B_E, div_busy, div_done};

    // Reference divide timeline: an issue in cycle t means busy over
    // t+1..t+L and done in t+L+1; a later issue or a reset replaces it.
    always @(posedge clk) begin
        if (rst) begin
            busyLo = -1;
            busyHi = -2;
            doneAt = -1;
        end else if (div_start_E) begin
            busyLo = cyc + 1;
            busyHi = cyc + L;
            doneAt = cyc + L + 1;
        end
        cyc = cyc + 1;
    end

    // Operand source from the forwarding rules, MEM before WB
    function automatic logic [1:0] refFwd(input logic [RW-1:0] src);
        if (Reg_Write_M && Write_Reg_M != 0 && Write_Reg_M == src) return 2'b10;
        if (Reg_Write_W && Write_Reg_W != 0 && Write_Reg_W == src) return 2'b01;
        return 2'b00;
    endfunction

    // Expected output vector for the current cycle's inputs and timeline
    function automatic logic [9:0] refOut();
        logic busy, done, lu, st;
        if (rst) return 10'b0;
        busy = (cyc >= busyLo) && (cyc <= busyHi);
        done = (cyc == doneAt);
        lu   = Mem_Read_E && (Rt_E != 0) && ((Rt_E == Rs_D) || (Rt_E == Rt_D));
        st   = lu || (busy && (mfhilo_D || div_D));
        return {st && !branch_taken_E, st && !branch_taken_E, branch_taken_E,
                st || branch_taken_E, refFwd(Rs_E), refFwd(Rt_E), busy, done};
    endfunction

    // Park every non-reset input at its quiet value
    task automatic idle();
        Rs_D = '0; Rt_D = '0; Rs_E = '0; Rt_E = '0;
        Write_Reg_M = '0; Write_Reg_W = '0;
        Mem_Read_E = 1'b0; Reg_Write_M = 1'b0; Reg_Write_W = 1'b0;
        branch_taken_E = 1'b0; div_D = 1'b0; mfhilo_D = 1'b0; div_start_E = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset must hold every output quiet even with hazards on the inputs
    task automatic test_reset();
        rst = 1'b1;
        idle();
        Mem_Read_E = 1'b1; Rt_E = 5'd8; Rs_D = 5'd8; Rs_E = 5'd3;
        Write_Reg_M = 5'd3; Reg_Write_M = 1'b1; mfhilo_D = 1'b1; div_start_E = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall_F, stall_D, flush_D, clr_E} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {stall_F, stall_D, flush_D, clr_E});
        end
        checks++;
        if ({fwd_A_E, fwd_B_E} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_fwd: got %b expected 0000", {fwd_A_E, fwd_B_E});
        end
        tick();
        branch_taken_E = 1'b1;
        @(negedge clk);
        checks++;
        if ({flush_D, clr_E, div_busy, div_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %b expected 0000", {flush_D, clr_E, div_busy, div_done});
        end
        tick();
        rst = 1'b0;
        idle();
        tick();
    endtask

    // Load-use stalls once; the bubble removes the load; register 0 is exempt
    task automatic test_load_use();
        idle();
        Mem_Read_E = 1'b1; Rt_E = 5'd8; Rs_D = 5'd8;
        @(negedge clk);
        checks++;
        if ({stall_F, stall_D, clr_E, flush_D} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL load_use_rs: got %b expected 1110", {stall_F, stall_D, clr_E, flush_D});
        end
        tick();
        Mem_Read_E = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_F, stall_D, clr_E} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL load_use_once: got %b expected 000", {stall_F, stall_D, clr_E});
        end
        tick();
        Mem_Read_E = 1'b1; Rt_E = 5'd12; Rs_D = 5'd1; Rt_D = 5'd12;
        @(negedge clk);
        checks++;
        if ({stall_F, stall_D, clr_E} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL load_use_rt: got %b expected 111", {stall_F, stall_D, clr_E});
        end
        tick();
        Rt_E = 5'd0; Rs_D = 5'd0; Rt_D = 5'd0;
        @(negedge clk);
        checks++;
        if ({stall_F, stall_D, clr_E} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL load_use_r0: got %b expected 000", {stall_F, stall_D, clr_E});
        end
        tick();
        idle();
    endtask

    // MEM beats WB; WB alone forwards; register 0 never forwards
    task automatic test_forwarding();
        idle();
        Rs_E = 5'd5; Rt_E = 5'd5; Write_Reg_M = 5'd5; Write_Reg_W = 5'd5;
        Reg_Write_M = 1'b1; Reg_Write_W = 1'b1;
        @(negedge clk);
        checks++;
        if ({fwd_A_E, fwd_B_E} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL fwd_mem_prio: got %b expected 1010", {fwd_A_E, fwd_B_E});
        end
        tick();
        Reg_Write_M = 1'b0;
        @(negedge clk);
        checks++;
        if ({fwd_A_E, fwd_B_E} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL fwd_wb: got %b expected 0101", {fwd_A_E, fwd_B_E});
        end
        tick();
        Reg_Write_M = 1'b1; Write_Reg_M = 5'd0; Rs_E = 5'd0; Rt_E = 5'd9;
        @(negedge clk);
        checks++;
        if ({fwd_A_E, fwd_B_E} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL fwd_r0: got %b expected 0000", {fwd_A_E, fwd_B_E});
        end
        tick();
        Rt_E = 5'd7; Write_Reg_M = 5'd7; Reg_Write_M = 1'b0; Write_Reg_W = 5'd7; Rs_E = 5'd6;
        @(negedge clk);
        checks++;
        if ({fwd_A_E, fwd_B_E} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL fwd_b_only: got %b expected 0001", {fwd_A_E, fwd_B_E});
        end
        tick();
        idle();
    endtask

    // mfhi held from the issue cycle: stalled t+1..t+L, released with done at t+L+1
    task automatic test_divide();
        idle();
        mfhilo_D = 1'b1; div_start_E = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall_F, div_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL div_issue: got %b expected 00", {stall_F, div_busy});
        end
        tick();
        div_start_E = 1'b0;
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            checks++;
            if ({stall_F, stall_D, clr_E, div_busy, div_done} !==
                ((k <= L) ? 5'b11110 : (k == L + 1) ? 5'b00001 : 5'b00000)) begin
                errors++;
                $display("[TB] FAIL div_interlock t+%0d: got %b expected %b", k,
                         {stall_F, stall_D, clr_E, div_busy, div_done},
                         (k <= L) ? 5'b11110 : (k == L + 1) ? 5'b00001 : 5'b00000);
            end
            tick();
        end
        idle();
    endtask

    // Branch wins over a combined stall and leaves the divider untouched
    task automatic test_branch();
        idle();
        div_start_E = 1'b1;
        tick();
        div_start_E = 1'b0;
        Mem_Read_E = 1'b1; Rt_E = 5'd8; Rs_D = 5'd8; div_D = 1'b1; branch_taken_E = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall_F, stall_D, flush_D, clr_E} !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL branch_over_stall: got %b expected 0011", {stall_F, stall_D, flush_D, clr_E});
        end
        tick();
        idle();
        for (int k = 2; k <= L + 1; k++) begin
            @(negedge clk);
            checks++;
            if ({div_busy, div_done} !== {(k <= L), (k == L + 1)}) begin
                errors++;
                $display("[TB] FAIL branch_div_sched t+%0d: got %b expected %b", k,
                         {div_busy, div_done}, {(k <= L), (k == L + 1)});
            end
            tick();
        end
    endtask

    // Reset three cycles into a divide: quiet outputs, no completion afterwards
    task automatic test_reset_mid_divide();
        idle();
        div_start_E = 1'b1;
        tick();
        div_start_E = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        mfhilo_D = 1'b1; Mem_Read_E = 1'b1; Rt_E = 5'd4; Rs_D = 5'd4;
        @(negedge clk);
        checks++;
        if (dutOut !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %b expected 0000000000", dutOut);
        end
        tick();
        rst = 1'b0;
        idle();
        for (int k = 4; k <= L + 3; k++) begin
            @(negedge clk);
            checks++;
            if ({div_busy, div_done} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_mid_abandon t+%0d: got %b expected 00", k, {div_busy, div_done});
            end
            tick();
        end
    endtask

    // A second issue at t+4 restarts the count: done moves to t+4+L+1
    task automatic test_reissue();
        idle();
        div_start_E = 1'b1;
        tick();
        div_start_E = 1'b0;
        tick();
        tick();
        tick();
        div_start_E = 1'b1;
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reissue_busy: got %b expected 1", div_busy);
        end
        tick();
        div_start_E = 1'b0;
        for (int k = 5; k <= L + 6; k++) begin
            @(negedge clk);
            checks++;
            if ({div_busy, div_done} !== {(k <= L + 4), (k == L + 5)}) begin
                errors++;
                $display("[TB] FAIL reissue_sched t+%0d: got %b expected %b", k,
                         {div_busy, div_done}, {(k <= L + 4), (k == L + 5)});
            end
            tick();
        end
    endtask

    // Random traffic over a small register range so hazards collide often
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            Rs_D           = RW'($urandom_range(0, 3));
            Rt_D           = RW'($urandom_range(0, 3));
            Rs_E           = RW'($urandom_range(0, 3));
            Rt_E           = RW'($urandom_range(0, 3));
            Write_Reg_M    = RW'($urandom_range(0, 3));
            Write_Reg_W    = RW'($urandom_range(0, 3));
            Mem_Read_E     = ($urandom_range(0, 2) == 0);
            Reg_Write_M    = $urandom_range(0, 1) != 0;
            Reg_Write_W    = $urandom_range(0, 1) != 0;
            branch_taken_E = ($urandom_range(0, 7) == 0);
            div_D          = ($urandom_range(0, 2) == 0);
            mfhilo_D       = ($urandom_range(0, 2) == 0);
            div_start_E    = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            checks++;
            if (dutOut !== refOut()) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %b expected %b", i, dutOut, refOut());
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_divide();
        test_branch();
        test_reset_mid_divide();
        test_reissue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
